// File: rtl/upsample2_layer_pkg.sv
// Shared definitions for the 2x upsampler: default channel width, FSM state
// encodings and a small elaboration-time helper.
package upsample2_layer_pkg;

  localparam int unsigned DW_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_DUP    = 2'd1,
    ST_REPLAY = 2'd2
  } state_t;

  // Larger of two values; keeps counter widths at least one bit.
  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/upsample2_layer_if.sv
// Pixel stream bundle for upsample2_layer.
//   in_valid/in_ready : input handshake, transfer = in_valid & in_ready
//   in_1..in_3        : channel 1..3 input pixel
//   out_valid         : output pixel qualifier (no backpressure)
//   out_1..out_3      : channel 1..3 output pixel
//   out_last          : final pixel of the output frame
// slave modport is the upsampler, master is the source/sink around it.
interface upsample2_layer_if #(
  parameter int unsigned DW = 8
) ();

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_1;
  logic [DW-1:0] in_2;
  logic [DW-1:0] in_3;
  logic          out_valid;
  logic [DW-1:0] out_1;
  logic [DW-1:0] out_2;
  logic [DW-1:0] out_3;
  logic          out_last;

  modport slave (
    input  in_valid, in_1, in_2, in_3,
    output in_ready, out_valid, out_1, out_2, out_3, out_last
  );

  modport master (
    output in_valid, in_1, in_2, in_3,
    input  in_ready, out_valid, out_1, out_2, out_3, out_last
  );

endinterface

// File: rtl/upsample2_linebuf.sv
// One input row of packed 3-channel pixels for the replayed output row.
//   clk       : write clock
//   wr_en     : store wr_data at wr_idx
//   wr_idx    : input column being accepted
//   wr_data   : packed {ch3, ch2, ch1} pixel
//   rd_idx    : replay column
//   rd_data_c : combinational read of rd_idx
// Contents are deliberately not reset; every entry is written before it is read.
module upsample2_linebuf
  import upsample2_layer_pkg::*;
#(
  parameter int unsigned IN_W   = 4,
  parameter int unsigned WORD_W = 24,
  localparam int unsigned AW    = max2(1, $clog2(IN_W))
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_idx,
  output logic [WORD_W-1:0] rd_data_c
);

  logic [WORD_W-1:0] mem [IN_W];

  // Single write port driven by the accept cycle.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data_c = mem[rd_idx];

endmodule

// File: rtl/upsample2_layer.sv
// 2x nearest-neighbour upsampler for 3-channel raster streams.
// Accepts an IN_W x IN_H frame over a valid/ready handshake and emits a
// 2*IN_W x 2*IN_H frame qualified by out_valid only (sink never stalls).
// Each accepted pixel is emitted twice (ACCEPT, DUP); after a full input row
// the stored row is replayed with every pixel doubled (REPLAY).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : upsample2_layer_if slave (handshake input, pixel output)
// Build option UPSAMPLE2_ZERO_FILL_EN: the DUP copy and all REPLAY pixels are
// driven as zero (zero-insertion unpool) with identical timing.
module upsample2_layer
  import upsample2_layer_pkg::*;
#(
  parameter int unsigned IN_W = 4,
  parameter int unsigned IN_H = 4,
  parameter int unsigned DW   = DW_DEFAULT
) (
  input logic              clk,
  input logic              rst_n,
  upsample2_layer_if.slave bus
);

  localparam int unsigned CW  = max2(1, $clog2(IN_W));
  localparam int unsigned RW  = max2(1, $clog2(IN_H));
  localparam int unsigned OCW = max2(1, $clog2(2 * IN_W));
  localparam int unsigned ORW = max2(1, $clog2(2 * IN_H));
  localparam int unsigned PW  = 3 * DW;

  localparam logic [CW-1:0]  COL_LAST  = CW'(IN_W - 1);
  localparam logic [RW-1:0]  ROW_LAST  = RW'(IN_H - 1);
  localparam logic [OCW-1:0] OCOL_LAST = OCW'(2 * IN_W - 1);
  localparam logic [ORW-1:0] OROW_LAST = ORW'(2 * IN_H - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  in_col_q, in_col_d;
  logic [RW-1:0]  in_row_q, in_row_d;
  logic [OCW-1:0] rep_q, rep_d;
  logic [OCW-1:0] out_col_q, out_col_d;
  logic [ORW-1:0] out_row_q, out_row_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic           out_last_q, out_last_d;
  logic [PW-1:0]  out_pix_q, out_pix_d;

  logic           xfer_c;
  logic           lb_wr_c;
  logic [PW-1:0]  in_pix_c;
  logic [PW-1:0]  lb_rd_c;

  assign xfer_c   = bus.in_valid & in_ready_q;
  assign in_pix_c = {bus.in_3, bus.in_2, bus.in_1};

  upsample2_linebuf #(
    .IN_W   (IN_W),
    .WORD_W (PW)
  ) u_linebuf (
    .clk       (clk),
    .wr_en     (lb_wr_c),
    .wr_idx    (in_col_q),
    .wr_data   (in_pix_c),
    .rd_idx    (CW'(rep_q >> 1)),
    .rd_data_c (lb_rd_c)
  );

  // Next-state, counter and output decode.
  always_comb begin
    state_d     = state_q;
    in_col_d    = in_col_q;
    in_row_d    = in_row_q;
    rep_d       = rep_q;
    out_col_d   = out_col_q;
    out_row_d   = out_row_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_pix_d   = out_pix_q;
    lb_wr_c     = 1'b0;

    unique case (state_q)
      ST_ACCEPT: begin
        if (xfer_c) begin
          lb_wr_c     = 1'b1;
          out_pix_d   = in_pix_c;
          out_valid_d = 1'b1;
          state_d     = ST_DUP;
        end else begin
          in_ready_d  = 1'b1;
        end
      end

      ST_DUP: begin
        // Second copy of the pixel still held in the output register.
        out_valid_d = 1'b1;
`ifdef UPSAMPLE2_ZERO_FILL_EN
        out_pix_d   = '0;
`endif
        if (in_col_q == COL_LAST) begin
          rep_d   = '0;
          state_d = ST_REPLAY;
        end else begin
          in_col_d   = in_col_q + CW'(1);
          in_ready_d = 1'b1;
          state_d    = ST_ACCEPT;
        end
      end

      ST_REPLAY: begin
        // rep_q walks 0..2*IN_W-1; its upper bits index the stored row.
        out_valid_d = 1'b1;
`ifdef UPSAMPLE2_ZERO_FILL_EN
        out_pix_d   = '0;
`else
        out_pix_d   = lb_rd_c;
`endif
        if (rep_q == OCOL_LAST) begin
          rep_d      = '0;
          in_col_d   = '0;
          in_row_d   = (in_row_q == ROW_LAST) ? '0 : in_row_q + RW'(1);
          in_ready_d = 1'b1;
          state_d    = ST_ACCEPT;
        end else begin
          rep_d = rep_q + OCW'(1);
        end
      end

      default: begin
        in_ready_d = 1'b1;
        state_d    = ST_ACCEPT;
      end
    endcase

    // Output raster position of the pixel emitted at this edge.
    if (out_valid_d) begin
      out_last_d = (out_col_q == OCOL_LAST) && (out_row_q == OROW_LAST);
      if (out_col_q == OCOL_LAST) begin
        out_col_d = '0;
        out_row_d = (out_row_q == OROW_LAST) ? '0 : out_row_q + ORW'(1);
      end else begin
        out_col_d = out_col_q + OCW'(1);
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCEPT;
      in_col_q    <= '0;
      in_row_q    <= '0;
      rep_q       <= '0;
      out_col_q   <= '0;
      out_row_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_pix_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_col_q    <= in_col_d;
      in_row_q    <= in_row_d;
      rep_q       <= rep_d;
      out_col_q   <= out_col_d;
      out_row_q   <= out_row_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_pix_q   <= out_pix_d;
    end
  end

  // Output frame end must line up with the last input row being replayed.
  always_ff @(posedge clk) begin
    if (rst_n && out_last_d) assert (in_row_q == ROW_LAST);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_1     = out_pix_q[DW-1:0];
  assign bus.out_2     = out_pix_q[2*DW-1:DW];
  assign bus.out_3     = out_pix_q[3*DW-1:2*DW];

endmodule

// File: tb/tb_upsample2_layer.sv
// Directed bench for upsample2_layer (IN_W = IN_H = 4, DW = 8).
// Honors UPSAMPLE2_ZERO_FILL_EN for the expected pixel values.
module tb_upsample2_layer;

  localparam int IN_W = 4;
  localparam int IN_H = 4;
  localparam int OW   = 2 * IN_W;
  localparam int FRO  = 4 * IN_W * IN_H;  // output pixels per frame
  localparam int FRI  = IN_W * IN_H;      // input pixels per frame

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  upsample2_layer_if #(.DW(8)) bus ();

  upsample2_layer #(.IN_W(IN_W), .IN_H(IN_H), .DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         idx;
    logic [7:0] c1;
    bit         last;
  } vec_t;

  vec_t tbl [12];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] q1 [$];
  logic [7:0] q2 [$];
  logic [7:0] q3 [$];
  bit         ql [$];
  int         qc [$];
  bit         rq [$];
  logic [7:0] src [$];
  bit         rec_rdy = 1'b0;
  int         rdy_c0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output and in_ready capture, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      q1.push_back(bus.out_1);
      q2.push_back(bus.out_2);
      q3.push_back(bus.out_3);
      ql.push_back(bus.out_last);
      qc.push_back(cyc);
    end
    if (rec_rdy && rq.size() < 4 * OW) begin
      if (rq.size() == 0) rdy_c0 = cyc;
      rq.push_back(bus.in_ready);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic clear_cap();
    q1.delete(); q2.delete(); q3.delete(); ql.delete(); qc.delete();
    src.delete();
  endtask

  function automatic logic [7:0] exp_ch(input int i, input int ch);
    int k, r, c;
    logic [7:0] v;
    k = i % FRO;
    r = k / OW;
    c = k % OW;
    v = src[(i / FRO) * FRI + (r / 2) * IN_W + c / 2];
    if (ch == 2) v = 8'hFF - v;
    else if (ch == 3) v = 8'h80 ^ v;
`ifdef UPSAMPLE2_ZERO_FILL_EN
    if ((r % 2) != 0 || (c % 2) != 0) v = 8'h00;
`endif
    return v;
  endfunction

  task automatic send(input logic [7:0] p, input int gap);
    int n;
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
      repeat (gap) begin @(posedge clk); #1; end
    end
    bus.in_valid = 1'b1;
    bus.in_1 = p;
    bus.in_2 = 8'hFF - p;
    bus.in_3 = 8'h80 ^ p;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) chk("send_timeout", 32'(bus.in_ready), 1);
    src.push_back(p);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    repeat (24) begin @(posedge clk); #1; end
  endtask

  task automatic check_stream(input string tag, input int nf);
    chk($sformatf("%s_count", tag), q1.size(), nf * FRO);
    for (int i = 0; i < q1.size() && i < nf * FRO; i++) begin
      chk($sformatf("%s_c1_%0d", tag, i), q1[i], exp_ch(i, 1));
      chk($sformatf("%s_c2_%0d", tag, i), q2[i], exp_ch(i, 2));
      chk($sformatf("%s_c3_%0d", tag, i), q3[i], exp_ch(i, 3));
      chk($sformatf("%s_last_%0d", tag, i), 32'(ql[i]), 32'((i % FRO) == FRO - 1));
    end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int bad;
`ifdef UPSAMPLE2_ZERO_FILL_EN
    tbl[0]  = '{0,  8'd1,  1'b0};  tbl[1]  = '{1,  8'd0,  1'b0};
    tbl[2]  = '{2,  8'd2,  1'b0};  tbl[3]  = '{7,  8'd0,  1'b0};
    tbl[4]  = '{8,  8'd0,  1'b0};  tbl[5]  = '{15, 8'd0,  1'b0};
    tbl[6]  = '{16, 8'd5,  1'b0};  tbl[7]  = '{23, 8'd0,  1'b0};
    tbl[8]  = '{40, 8'd0,  1'b0};  tbl[9]  = '{48, 8'd13, 1'b0};
    tbl[10] = '{62, 8'd0,  1'b0};  tbl[11] = '{63, 8'd0,  1'b1};
`else
    tbl[0]  = '{0,  8'd1,  1'b0};  tbl[1]  = '{1,  8'd1,  1'b0};
    tbl[2]  = '{2,  8'd2,  1'b0};  tbl[3]  = '{7,  8'd4,  1'b0};
    tbl[4]  = '{8,  8'd1,  1'b0};  tbl[5]  = '{15, 8'd4,  1'b0};
    tbl[6]  = '{16, 8'd5,  1'b0};  tbl[7]  = '{23, 8'd8,  1'b0};
    tbl[8]  = '{40, 8'd9,  1'b0};  tbl[9]  = '{48, 8'd13, 1'b0};
    tbl[10] = '{62, 8'd16, 1'b0};  tbl[11] = '{63, 8'd16, 1'b1};
`endif
    bus.in_valid = 1'b0;
    bus.in_1 = 8'h00; bus.in_2 = 8'h00; bus.in_3 = 8'h00;

    // Reset values, then in_ready rises on the first cycle after release.
    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_1", bus.out_1, 0);
    chk("rst_out_last", 32'(bus.out_last), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);
    chk("post_rst_out_valid", 32'(bus.out_valid), 0);

    // Scenario 1: 1..16 with in_valid held high.
    clear_cap();
    rec_rdy = 1'b1;
    for (int k = 1; k <= FRI; k++) send(8'(k), 0);
    drain();
    rec_rdy = 1'b0;
    foreach (tbl[v]) begin
      if (tbl[v].idx < q1.size()) begin
        chk($sformatf("s1_tbl_c1_%0d", tbl[v].idx), q1[tbl[v].idx], tbl[v].c1);
        chk($sformatf("s1_tbl_last_%0d", tbl[v].idx), 32'(ql[tbl[v].idx]), 32'(tbl[v].last));
      end else begin
        chk($sformatf("s1_tbl_missing_%0d", tbl[v].idx), q1.size(), tbl[v].idx + 1);
      end
    end
    check_stream("s1", 1);
    chk("s1_rdy_count", rq.size(), 4 * OW);
    for (int k = 0; k < rq.size(); k++)
      chk($sformatf("s1_in_ready_%0d", k), 32'(rq[k]),
          32'(((k % (2 * OW)) < OW) && ((k % 2) == 0)));
    if (qc.size() == FRO) begin
      chk("s1_latency", qc[0] - rdy_c0, 1);
      chk("s1_contiguous", qc[FRO-1] - qc[0], FRO - 1);
    end

    // Scenario 2: random gaps, ch2/ch3 pass-through.
    clear_cap();
    for (int k = 0; k < FRI; k++) send(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    drain();
    check_stream("s2", 1);

    // Scenario 3: 5 idle accept cycles before pixel 3.
    clear_cap();
    for (int k = 1; k <= FRI; k++) send(8'(k), (k == 3) ? 5 : 0);
    drain();
    check_stream("s3", 1);
    if (qc.size() >= 2 * OW) begin
      chk("s3_bubbles_row0", qc[4] - qc[3], 6);
      bad = 0;
      for (int i = 0; i < 2 * OW - 1; i++)
        if (i != 3 && qc[i+1] - qc[i] != 1) bad++;
      chk("s3_other_gaps", bad, 0);
      chk("s3_row1_contig", qc[2*OW-1] - qc[OW], OW - 1);
    end

    // Scenario 4: reset in the middle of the second REPLAY.
    clear_cap();
    for (int k = 1; k <= 2 * IN_W; k++) send(8'(50 + k), 0);
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("s4_in_replay", 32'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("s4_rst_out_valid", 32'(bus.out_valid), 0);
    chk("s4_rst_out_1", bus.out_1, 0);
    chk("s4_rst_out_2", bus.out_2, 0);
    chk("s4_rst_out_3", bus.out_3, 0);
    chk("s4_rst_out_last", 32'(bus.out_last), 0);
    chk("s4_rst_in_ready", 32'(bus.in_ready), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    clear_cap();
    for (int k = 101; k <= 100 + FRI; k++) send(8'(k), 0);
    drain();
    check_stream("s4", 1);

    // Scenario 5: two frames back to back.
    clear_cap();
    for (int k = 1; k <= 2 * FRI; k++) send(8'(30 + k), 0);
    drain();
    check_stream("s5", 2);
    if (qc.size() == 2 * FRO) begin
      chk("s5_f2_start", qc[FRO] - qc[FRO-1], 1);
      bad = 0;
      for (int i = 0; i < 2 * FRO - 1; i++)
        if (qc[i+1] - qc[i] != 1) bad++;
      chk("s5_gapless", bad, 0);
    end

    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
